// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: merges pipeline writebacks with a multi-cycle
// source (load return / CSR), buffering one losing pipeline write and stalling.
module rf_wr_arbiter #(
  parameter int unsigned MS_MAX_WAIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pipe_wr_en_in,
  input  logic [4:0]  pipe_rd_addr_in,
  input  logic [31:0] pipe_wr_data_in,
  input  logic        ms_req_in,
  input  logic [4:0]  ms_rd_addr_in,
  input  logic [31:0] ms_data_in,
  output logic        ms_ack_out,
  output logic        stall_out,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_wr_data_out
);

  typedef enum logic {PASS, HOLD} state_e;

  localparam logic [3:0] MaxWait = 4'(MS_MAX_WAIT);

  state_e      state_q, state_d;
  logic [4:0]  bufAddr_q, bufAddr_d;
  logic [31:0] bufData_q, bufData_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        stall_q;
  logic        rfWrEn_q, rfWrEn_d;
  logic [4:0]  rfAddr_q, rfAddr_d;
  logic [31:0] rfData_q, rfData_d;

  logic        pipeCand;
  logic [4:0]  pipeAddr;
  logic [31:0] pipeData;
  logic        msWin;
  logic        pipeWin;

  // In HOLD the buffered entry is the only pipe candidate; live pipe inputs are ignored.
  always_comb begin
    pipeCand = (state_q == HOLD) || pipe_wr_en_in;
    pipeAddr = (state_q == HOLD) ? bufAddr_q : pipe_rd_addr_in;
    pipeData = (state_q == HOLD) ? bufData_q : pipe_wr_data_in;
    msWin    = ms_req_in && (!pipeCand || (waitCnt_q == MaxWait));
    pipeWin  = pipeCand && !msWin;
  end

  assign ms_ack_out = msWin && !rst_in;

  always_comb begin
    state_d   = state_q;
    bufAddr_d = bufAddr_q;
    bufData_d = bufData_q;
    waitCnt_d = waitCnt_q;
    rfWrEn_d  = 1'b0;
    rfAddr_d  = rfAddr_q;
    rfData_d  = rfData_q;

    if (msWin || !ms_req_in) begin
      waitCnt_d = 4'd0;
    end else if (waitCnt_q != MaxWait) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end

    // x0 writes are still granted so the sources progress, but never enabled.
    if (msWin) begin
      rfWrEn_d = (ms_rd_addr_in != 5'd0);
      rfAddr_d = ms_rd_addr_in;
      rfData_d = ms_data_in;
    end else if (pipeWin) begin
      rfWrEn_d = (pipeAddr != 5'd0);
      rfAddr_d = pipeAddr;
      rfData_d = pipeData;
    end

    case (state_q)
      PASS: begin
        if (pipe_wr_en_in && msWin) begin
          state_d   = HOLD;
          bufAddr_d = pipe_rd_addr_in;
          bufData_d = pipe_wr_data_in;
        end
      end
      HOLD: begin
        if (pipeWin) begin
          state_d = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= PASS;
      bufAddr_q <= 5'd0;
      bufData_q <= 32'd0;
      waitCnt_q <= 4'd0;
      stall_q   <= 1'b0;
      rfWrEn_q  <= 1'b0;
      rfAddr_q  <= 5'd0;
      rfData_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      bufAddr_q <= bufAddr_d;
      bufData_q <= bufData_d;
      waitCnt_q <= waitCnt_d;
      stall_q   <= (state_d == HOLD);
      rfWrEn_q  <= rfWrEn_d;
      rfAddr_q  <= rfAddr_d;
      rfData_q  <= rfData_d;
    end
  end

  assign stall_out      = stall_q;
  assign rf_wr_en_out   = rfWrEn_q;
  assign rf_rd_addr_out = rfAddr_q;
  assign rf_wr_data_out = rfData_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: expected register-file writes are queued when
// each cycle is driven and popped when the registered outputs appear.
module tb_rf_wr_arbiter;

  localparam int unsigned MAXW = 4;

  logic        clk_in;
  logic        rst_in;
  logic        pipe_wr_en_in;
  logic [4:0]  pipe_rd_addr_in;
  logic [31:0] pipe_wr_data_in;
  logic        ms_req_in;
  logic [4:0]  ms_rd_addr_in;
  logic [31:0] ms_data_in;
  logic        ms_ack_out;
  logic        stall_out;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_addr_out;
  logic [31:0] rf_wr_data_out;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } rfExp_t;

  rfExp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  rf_wr_arbiter #(.MS_MAX_WAIT(MAXW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pipe_wr_en_in   (pipe_wr_en_in),
    .pipe_rd_addr_in (pipe_rd_addr_in),
    .pipe_wr_data_in (pipe_wr_data_in),
    .ms_req_in       (ms_req_in),
    .ms_rd_addr_in   (ms_rd_addr_in),
    .ms_data_in      (ms_data_in),
    .ms_ack_out      (ms_ack_out),
    .stall_out       (stall_out),
    .rf_wr_en_out    (rf_wr_en_out),
    .rf_rd_addr_out  (rf_rd_addr_out),
    .rf_wr_data_out  (rf_wr_data_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: drive at negedge, check combinational ack and stall,
  // queue the expected write, then compare it after the rising edge.
  task automatic applyStimulus(input string tag,
                               input logic pEn, input logic [4:0] pAddr, input logic [31:0] pData,
                               input logic mReq, input logic [4:0] mAddr, input logic [31:0] mData,
                               input logic expAck, input logic expStall,
                               input logic expEn, input logic [4:0] expAddr, input logic [31:0] expData);
    rfExp_t e;
    @(negedge clk_in);
    rst_in          = 1'b0;
    pipe_wr_en_in   = pEn;
    pipe_rd_addr_in = pAddr;
    pipe_wr_data_in = pData;
    ms_req_in       = mReq;
    ms_rd_addr_in   = mAddr;
    ms_data_in      = mData;
    #1;
    checkOutput({tag, ".ack"},   32'(ms_ack_out), 32'(expAck));
    checkOutput({tag, ".stall"}, 32'(stall_out),  32'(expStall));
    sb.push_back('{expEn, expAddr, expData});
    @(posedge clk_in);
    #1;
    if (sb.size() == 0) begin
      checkOutput({tag, ".sbEmpty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, ".en"},   32'(rf_wr_en_out),   32'(e.en));
      checkOutput({tag, ".addr"}, 32'(rf_rd_addr_out), 32'(e.addr));
      checkOutput({tag, ".data"}, rf_wr_data_out,      e.data);
    end
  endtask

  initial begin
    rst_in          = 1'b1;
    pipe_wr_en_in   = 1'b0;
    pipe_rd_addr_in = 5'd0;
    pipe_wr_data_in = 32'd0;
    ms_req_in       = 1'b1;
    ms_rd_addr_in   = 5'd2;
    ms_data_in      = 32'h55;

    // Reset holds everything at zero, even with a request present.
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("rst.ack",   32'(ms_ack_out),   32'd0);
    checkOutput("rst.stall", 32'(stall_out),    32'd0);
    checkOutput("rst.en",    32'(rf_wr_en_out), 32'd0);
    checkOutput("rst.addr",  32'(rf_rd_addr_out), 32'd0);
    checkOutput("rst.data",  rf_wr_data_out,    32'd0);
    ms_req_in = 1'b0;

    $display("[TB] basic pipe and ms writes");
    applyStimulus("pipe5", 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    applyStimulus("idle1", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd5, 32'hDEADBEEF);
    applyStimulus("ms7",   0, 5'd0, 32'd0, 1, 5'd7, 32'h11, 1, 0, 1, 5'd7, 32'h11);

    $display("[TB] starvation limit with pipe writes every cycle");
    for (int i = 0; i < MAXW; i++)
      applyStimulus("starve", 1, 5'(10 + i), 32'h100 + 32'(i), 1, 5'd9, 32'hA5A5, 0, 0,
                    1, 5'(10 + i), 32'h100 + 32'(i));
    applyStimulus("forced", 1, 5'd14, 32'h104, 1, 5'd9, 32'hA5A5, 1, 0, 1, 5'd9, 32'hA5A5);
    applyStimulus("bufOut", 1, 5'd20, 32'hBAD, 0, 5'd0, 32'd0, 0, 1, 1, 5'd14, 32'h104);
    applyStimulus("idle2",  0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd14, 32'h104);

    $display("[TB] x0 writes dropped");
    applyStimulus("pipe0", 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'hFFFFFFFF);
    applyStimulus("ms0",   0, 5'd0, 32'd0, 1, 5'd0, 32'h22, 1, 0, 0, 5'd0, 32'h22);

    $display("[TB] same rd on both sources, then buffered entry beats fresh ms");
    for (int i = 0; i < MAXW; i++)
      applyStimulus("sameRdWait", 1, 5'(1 + i), 32'h200 + 32'(i), 1, 5'd3, 32'h33, 0, 0,
                    1, 5'(1 + i), 32'h200 + 32'(i));
    applyStimulus("sameRdMs",  1, 5'd3, 32'h3B, 1, 5'd3, 32'h33, 1, 0, 1, 5'd3, 32'h33);
    applyStimulus("sameRdBuf", 1, 5'd25, 32'hBAD, 1, 5'd6, 32'h66, 0, 1, 1, 5'd3, 32'h3B);
    applyStimulus("msAfterBuf", 0, 5'd0, 32'd0, 1, 5'd6, 32'h66, 1, 0, 1, 5'd6, 32'h66);

    $display("[TB] reset during HOLD with ms pending");
    for (int i = 0; i < MAXW; i++)
      applyStimulus("rstWait", 1, 5'(16 + i), 32'h300 + 32'(i), 1, 5'd8, 32'h88, 0, 0,
                    1, 5'(16 + i), 32'h300 + 32'(i));
    applyStimulus("rstForced", 1, 5'd21, 32'h21, 1, 5'd8, 32'h88, 1, 0, 1, 5'd8, 32'h88);
    @(negedge clk_in);
    pipe_wr_en_in = 1'b0;
    ms_req_in     = 1'b1;
    ms_rd_addr_in = 5'd12;
    ms_data_in    = 32'hCC;
    rst_in        = 1'b1;
    #1;
    checkOutput("midRst.ack",   32'(ms_ack_out),     32'd0);
    checkOutput("midRst.stall", 32'(stall_out),      32'd0);
    checkOutput("midRst.en",    32'(rf_wr_en_out),   32'd0);
    checkOutput("midRst.addr",  32'(rf_rd_addr_out), 32'd0);
    checkOutput("midRst.data",  rf_wr_data_out,      32'd0);
    applyStimulus("postRstMs", 0, 5'd0, 32'd0, 1, 5'd12, 32'hCC, 1, 0, 1, 5'd12, 32'hCC);
    applyStimulus("postRstIdle", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd12, 32'hCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
